// File: rtl/dvsd_pkg.sv
// Shared types and helpers for the dvsd priority-decoder receive path.
package dvsd_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2
    } pd_state_t;

    function automatic logic [ONEHOT_W-1:0] decode_onehot(input logic [CODE_W-1:0] code);
        logic [ONEHOT_W-1:0] oh;
        oh       = '0;
        oh[code] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dvsd_code_fifo.sv
// Synchronous code queue; pointers wrap naturally because DEPTH is a power of two.
module dvsd_code_fifo
    import dvsd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CODE_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dvsd_pd.sv
// Sequential 3-to-8 decoder: queues encoder codes and presents each as a held one-hot.
//   state    | meaning
//   ST_IDLE  | nothing driven; pops the queue head when enabled and non-empty
//   ST_DRIVE | one-hot held for the minimum hold time; ack ignored
//   ST_WAIT  | one-hot held until out_ack retires it
module dvsd_pd
    import dvsd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [CODE_W-1:0]   code_in,
    input  logic                gs_in,
    output logic                code_rdy,
    output logic [ONEHOT_W-1:0] out,
    output logic                out_valid,
    input  logic                out_ack,
    output logic                eno,
    output logic                ovf
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD - 1);

    pd_state_t                 state, state_nxt;
    logic [ONEHOT_W-1:0]       out_nxt;
    logic                      valid_nxt;
    logic [HW-1:0]             hold_cnt, hold_nxt;
    logic                      ovf_nxt;
    logic                      pop;
    logic                      push;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CODE_W-1:0]         head;
    logic [$clog2(DEPTH):0]    fifo_count;

    assign code_rdy = ~fifo_full;
    assign push     = en & gs_in & code_rdy;
    assign eno      = en & (fifo_count == '0) & (state == ST_IDLE);

    dvsd_code_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (~en),
        .din   (code_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        out_nxt   = out;
        valid_nxt = out_valid;
        hold_nxt  = hold_cnt;
        pop       = 1'b0;
        ovf_nxt   = ovf | (en & gs_in & fifo_full);

        if (!en) begin
            state_nxt = ST_IDLE;
            out_nxt   = '0;
            valid_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        out_nxt   = decode_onehot(head);
                        valid_nxt = 1'b1;
                        hold_nxt  = HOLD_INIT;
                        state_nxt = ST_DRIVE;
                    end else begin
                        out_nxt   = '0;
                        valid_nxt = 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (hold_cnt == '0) state_nxt = ST_WAIT;
                    else                hold_nxt  = hold_cnt - 1'b1;
                end
                ST_WAIT: begin
                    // Back-to-back reload keeps out_valid high across indices.
                    if (out_ack) begin
                        if (!fifo_empty) begin
                            pop       = 1'b1;
                            out_nxt   = decode_onehot(head);
                            valid_nxt = 1'b1;
                            hold_nxt  = HOLD_INIT;
                            state_nxt = ST_DRIVE;
                        end else begin
                            out_nxt   = '0;
                            valid_nxt = 1'b0;
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: begin
                    out_nxt   = '0;
                    valid_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            hold_cnt  <= '0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_nxt;
            out       <= out_nxt;
            out_valid <= valid_nxt;
            hold_cnt  <= hold_nxt;
            ovf       <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_dvsd_pd.sv
// Directed bench for dvsd_pd with DEPTH=4, HOLD=2.
module tb_dvsd_pd;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] code_in;
    logic       gs_in;
    logic       code_rdy;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ack;
    logic       eno;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    dvsd_pd #(.DEPTH(4), .HOLD(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .code_in   (code_in),
        .gs_in     (gs_in),
        .code_rdy  (code_rdy),
        .out       (out),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .eno       (eno),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        gs_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int idx, k, run, n;
        logic gap, saw_stall, started, prev_valid;
        logic [7:0] prev_out;

        reset   = 1'b1;
        en      = 1'b1;
        code_in = '0;
        gs_in   = 1'b0;
        out_ack = 1'b0;

        // reset then idle
        tick();
        tick();
        check_val("rst_out", 32'(out), 32'h00);
        check_val("rst_valid", 32'(out_valid), 0);
        check_val("rst_rdy", 32'(code_rdy), 1);
        check_val("rst_eno", 32'(eno), 1);
        check_val("rst_ovf", 32'(ovf), 0);
        reset = 1'b0;
        tick();

        // single decode, ack tied high
        out_ack = 1'b1;
        gs_in   = 1'b1;
        code_in = 3'd5;
        tick();
        gs_in = 1'b0;
        check_val("single_n_valid", 32'(out_valid), 0);
        check_val("single_n_eno", 32'(eno), 0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_val("single_out", 32'(out), 32'h20);
            check_val("single_valid", 32'(out_valid), 1);
        end
        tick();
        check_val("single_end_out", 32'(out), 32'h00);
        check_val("single_end_valid", 32'(out_valid), 0);
        check_val("single_end_eno", 32'(eno), 1);

        // back-to-back sweep 0..7 stalling on code_rdy
        idx = 0; k = 0; run = 0;
        gap = 0; saw_stall = 0; started = 0; prev_valid = 0; prev_out = '0;
        for (int cyc = 0; cyc < 120 && !(k == 8 && !out_valid); cyc++) begin
            if (idx < 8 && code_rdy) begin
                gs_in   = 1'b1;
                code_in = 3'(idx);
            end else begin
                gs_in = 1'b0;
                if (idx < 8) saw_stall = 1'b1;
            end
            tick();
            if (gs_in) idx++;
            if (out_valid && (!prev_valid || out != prev_out)) begin
                if (prev_valid) check_val("sweep_residence", 32'(run), 3);
                check_val("sweep_out", 32'(out), 32'(1) << k);
                k++;
                run = 1;
            end else if (out_valid) begin
                run++;
            end
            if (started && !out_valid && k < 8) gap = 1'b1;
            if (out_valid) started = 1'b1;
            prev_valid = out_valid;
            prev_out   = out;
        end
        gs_in = 1'b0;
        check_val("sweep_count", 32'(k), 8);
        check_val("sweep_gap", 32'(gap), 0);
        check_val("sweep_stall", 32'(saw_stall), 1);
        check_val("sweep_ovf", 32'(ovf), 0);

        // overflow: six pushes with no ack
        do_reset();
        out_ack = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            gs_in   = 1'b1;
            code_in = 3'(c);
            tick();
        end
        gs_in = 1'b0;
        check_val("ovf_set", 32'(ovf), 1);
        check_val("ovf_head", 32'(out), 32'h02);
        check_val("ovf_rdy", 32'(code_rdy), 0);
        out_ack    = 1'b1;
        prev_out   = out;
        n          = 0;
        for (int cyc = 0; cyc < 40 && out_valid; cyc++) begin
            tick();
            if (out_valid && out != prev_out) begin
                check_val("ovf_drain_out", 32'(out), 32'(1) << (2 + n));
                n++;
            end
            prev_out = out;
        end
        check_val("ovf_drain_count", 32'(n), 4);
        check_val("ovf_sticky", 32'(ovf), 1);
        en = 1'b0;
        tick();
        check_val("ovf_keep_en_low", 32'(ovf), 1);
        en = 1'b1;
        do_reset();
        check_val("ovf_cleared", 32'(ovf), 0);

        // early ack ignored in DRIVE
        out_ack = 1'b0;
        gs_in   = 1'b1;
        code_in = 3'd3;
        tick();
        gs_in = 1'b0;
        tick();
        check_val("early_load", 32'(out), 32'h08);
        out_ack = 1'b1;
        tick();
        check_val("early_drive1", 32'(out), 32'h08);
        tick();
        check_val("early_drive0", 32'(out), 32'h08);
        check_val("early_valid", 32'(out_valid), 1);
        out_ack = 1'b0;
        tick();
        check_val("early_wait", 32'(out), 32'h08);
        out_ack = 1'b1;
        tick();
        check_val("early_retire_out", 32'(out), 32'h00);
        check_val("early_retire_valid", 32'(out_valid), 0);

        // en drop while in WAIT with two queued
        do_reset();
        out_ack = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            gs_in   = 1'b1;
            code_in = 3'(c);
            tick();
        end
        gs_in = 1'b0;
        tick();
        check_val("endrop_pre_out", 32'(out), 32'h02);
        check_val("endrop_pre_rdy", 32'(code_rdy), 1);
        en = 1'b0;
        #1;
        check_val("endrop_eno_comb", 32'(eno), 0);
        tick();
        check_val("endrop_out", 32'(out), 32'h00);
        check_val("endrop_valid", 32'(out_valid), 0);
        check_val("endrop_eno", 32'(eno), 0);
        en = 1'b1;
        #1;
        check_val("endrop_eno_back", 32'(eno), 1);
        out_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_val("endrop_no_stale", 32'(out_valid), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dvsd_pd.md
Name: dvsd_pd

Overview:
- Sequential 3-to-8 decoder: the receiving end of the dvsd priority-encoder interface.
- Accepts encoded indices (code, gs strobe, en) from a dvsd_pe-style source and buffers them in a small queue.
- Drives each index as a one-hot output for a minimum hold time, then waits for a downstream acknowledge before retiring it.
- Sits between the encoder and one-hot consumers (LED/grant lines) in the sky130 demo design.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- HOLD, 2, minimum cycles a one-hot output is driven before ack is honoured; minimum 1.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  decoder enable, same meaning as the encoder's en.
- code_in  input  3  encoded index; 0 selects bit 0, 7 selects bit 7.
- gs_in  input  1  code_in valid strobe; the encoder's gs.
- code_rdy  output  1  queue can accept a code (not full).
- out  output  8  one-hot decoded index; all zeros when idle.
- out_valid  output  1  out holds a live index.
- out_ack  input  1  consumer retires the current index.
- eno  output  1  en high and nothing pending (queue empty, FSM IDLE).
- ovf  output  1  sticky: a strobe was dropped because the queue was full.

Behaviour:
- Reset (sync, active-high) applies at the next edge regardless of state, including mid-DRIVE or mid-WAIT:
  - out=0, out_valid=0, ovf=0, queue emptied, FSM=IDLE.
  - code_rdy=1; eno follows en.
- Push:
  - A code is pushed when en & gs_in & code_rdy at an edge.
  - code_rdy = ~full, computed from the registered count; there is no same-cycle bypass.
- Overflow: en & gs_in & full sets ovf; the code is discarded and ovf stays set until reset.
- FSM has three states: IDLE, DRIVE, WAIT.
- IDLE:
  - If en and the queue is non-empty: pop the head, load out = 1<<code, set out_valid=1, load hold counter = HOLD-1, go to DRIVE.
  - Otherwise out=0 and out_valid=0.
- DRIVE:
  - If the counter is 0, go to WAIT; otherwise decrement.
  - out_ack is ignored in this state.
- WAIT:
  - On out_ack with queue non-empty: pop the next entry and go to DRIVE back-to-back, with no out_valid gap.
  - On out_ack with queue empty: clear out and out_valid, go to IDLE.
- Latency:
  - From a push into an empty queue with the FSM in IDLE, out_valid rises after the second edge (push edge, then pop edge).
  - Minimum residence per index is HOLD+1 cycles when ack is held high: HOLD cycles in DRIVE plus one in WAIT.
- Simultaneous push and pop are legal in one cycle. Count is unchanged and the pointers advance independently, wrapping modulo DEPTH.
- Push on an empty queue is not visible to the pop decision in the same cycle.
- en low:
  - Next edge: queue flushed, FSM=IDLE, out=0, out_valid=0; pushes blocked.
  - Combinationally: eno=0.
  - ovf is preserved.
- eno = en & (count==0) & (state==IDLE), combinational from registers and en.
- out is always zero or exactly one-hot. It is never X after reset.

Decomposition:
- Package dvsd_pkg:
  - FSM state enum (IDLE/DRIVE/WAIT).
  - CODE_W=3, ONEHOT_W=8.
  - A decode function code to one-hot.
- Sub-module dvsd_code_fifo:
  - Sync FIFO of CODE_W-bit entries with DEPTH.
  - Ports: push, pop, flush, full, empty, count.
- Top dvsd_pd: FSM, hold counter, ovf, eno.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with en=1 -> out=8'h00, out_valid=0, code_rdy=1, eno=1, ovf=0.
- Single decode: push code 5 at edge N with HOLD=2, out_ack tied high -> out=8'b00100000 and out_valid=1 after edge N+1, held 3 cycles, then out=0 and eno=1.
- Back-to-back sweep: push codes 0..7 on consecutive cycles with out_ack=1 -> out steps 01,02,04,...,80 with no out_valid gap. code_rdy drops once 4 are queued, and the bench stalls on code_rdy; ovf stays 0.
- Overflow: out_ack=0, push 6 codes -> first popped into DRIVE, next 4 queued, 6th sets ovf=1 and is dropped; ovf stays 1 through acks until reset.
- Early ack ignored: pulse out_ack during DRIVE -> out holds; retire occurs only on ack in WAIT.
- en drop mid-operation: en=0 while in WAIT with 2 queued -> eno=0 immediately; next edge out=0, out_valid=0, queue empty. With en=1 again, eno=1 and no stale codes are emitted.
